// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the project CPU datapath.
// Sequences every instruction through FETCH, DECODE, EXEC, MEM and WB.
// It drives the datapath write strobes and the shared multiplexer selects.
// The state register is the only storage; every output is decoded
// combinationally from state, opcode, funct and zero.
// Optional feature macro: JAL_JR_EN adds the jal and jr instructions.
// When JAL_JR_EN is undefined, both instructions decode as illegal.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic       mem_re,
    output logic       mem_we,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [1:0] pc_src,
    output logic       alu_src_b,
    output logic [1:0] ext_op,
    output logic [2:0] alu_op,
    output logic       illegal,
    output logic [2:0] state
);

    // Opcode and funct field values of the supported instructions.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
`ifdef JAL_JR_EN
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
`endif

    // Multiplexer select encodings seen by the datapath.
    localparam logic [1:0] DST_RT   = 2'd0;
    localparam logic [1:0] DST_RD   = 2'd1;
    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_MEM   = 2'd1;
    localparam logic [1:0] PC_SEQ   = 2'd0;
    localparam logic [1:0] PC_BR    = 2'd1;
    localparam logic [1:0] PC_JMP   = 2'd2;
    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;
`ifdef JAL_JR_EN
    localparam logic [1:0] DST_RA   = 2'd2;
    localparam logic [1:0] WB_PC4   = 2'd2;
    localparam logic [1:0] PC_RS    = 2'd3;
`endif

    // The state codes are visible on the debug port, so they are fixed.
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_RST    = 3'd7
    } state_t;

    // Instruction class: shared by the DECODE, EXEC, MEM and WB decode.
    typedef enum logic [3:0] {
        I_BAD, I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW,
        I_BEQ, I_J, I_JAL, I_JR
    } instr_t;

    state_t state_reg;
    state_t state_next;
    instr_t instr;

    // Classify the instruction held in IR. Any encoding not listed is I_BAD.
    always_comb begin
        instr = I_BAD;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: instr = I_ADDU;
                    FN_SUBU: instr = I_SUBU;
`ifdef JAL_JR_EN
                    FN_JR:   instr = I_JR;
`endif
                    default: instr = I_BAD;
                endcase
            end
            OP_ORI:  instr = I_ORI;
            OP_LUI:  instr = I_LUI;
            OP_LW:   instr = I_LW;
            OP_SW:   instr = I_SW;
            OP_BEQ:  instr = I_BEQ;
            OP_J:    instr = I_J;
`ifdef JAL_JR_EN
            OP_JAL:  instr = I_JAL;
`endif
            default: instr = I_BAD;
        endcase
    end

    // State register. An asynchronous reset abandons the current instruction
    // at once, so an outstanding MEM request is withdrawn in the same instant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_RST;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and per-state outputs. Every strobe and select defaults to 0.
    always_comb begin
        state_next = state_reg;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        reg_dst    = DST_RT;
        mem_to_reg = WB_ALU;
        pc_src     = PC_SEQ;
        alu_src_b  = 1'b0;
        ext_op     = EXT_ZERO;
        alu_op     = ALU_ADD;
        illegal    = 1'b0;
        case (state_reg)
            S_RST: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                // Load IR and advance the PC to PC+4 in the same cycle.
                ir_we      = 1'b1;
                pc_we      = 1'b1;
                pc_src     = PC_SEQ;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                // An unsupported word is flagged once and then acts as a nop.
                if (instr == I_BAD) begin
                    illegal    = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                state_next = S_WB;
                case (instr)
                    I_ADDU: begin
                        alu_op = ALU_ADD;
                    end
                    I_SUBU: begin
                        alu_op = ALU_SUB;
                    end
                    I_ORI: begin
                        alu_op    = ALU_OR;
                        alu_src_b = 1'b1;
                        ext_op    = EXT_ZERO;
                    end
                    I_LUI: begin
                        // The datapath forces ALU input A to zero for lui.
                        alu_op    = ALU_ADD;
                        alu_src_b = 1'b1;
                        ext_op    = EXT_LUI;
                    end
                    I_LW, I_SW: begin
                        alu_op     = ALU_ADD;
                        alu_src_b  = 1'b1;
                        ext_op     = EXT_SIGN;
                        state_next = S_MEM;
                    end
                    I_BEQ: begin
                        // The PC already holds PC+4, so a failed branch writes nothing.
                        alu_op     = ALU_SUB;
                        pc_src     = PC_BR;
                        pc_we      = zero;
                        state_next = S_FETCH;
                    end
                    I_J: begin
                        pc_src     = PC_JMP;
                        pc_we      = 1'b1;
                        state_next = S_FETCH;
                    end
`ifdef JAL_JR_EN
                    I_JAL: begin
                        // Link and jump complete together, so jal needs no WB.
                        pc_src     = PC_JMP;
                        pc_we      = 1'b1;
                        reg_we     = 1'b1;
                        reg_dst    = DST_RA;
                        mem_to_reg = WB_PC4;
                        state_next = S_FETCH;
                    end
                    I_JR: begin
                        pc_src     = PC_RS;
                        pc_we      = 1'b1;
                        state_next = S_FETCH;
                    end
`endif
                    default: begin
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                // Hold the request until memory accepts it. Any other class
                // cannot reach MEM, but it leaves at once rather than hang.
                mem_re = (instr == I_LW);
                mem_we = (instr == I_SW);
                if (mem_ready || !(instr == I_LW || instr == I_SW)) begin
                    state_next = (instr == I_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                reg_dst    = (instr == I_ADDU || instr == I_SUBU) ? DST_RD : DST_RT;
                mem_to_reg = (instr == I_LW) ? WB_MEM : WB_ALU;
                state_next = S_FETCH;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    assign state = state_reg;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized self-checking bench for mc_ctrl.
// Each instruction is expanded into its expected cycle-by-cycle output list,
// built from the instruction rules. A compare process checks the DUT against
// that list on every falling clock edge.
module tb_mc_ctrl;

`ifdef JAL_JR_EN
    localparam bit JJ_EN = 1'b1;
`else
    localparam bit JJ_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_we, ir_we, reg_we, mem_re, mem_we, alu_src_b, illegal;
    logic [1:0] reg_dst, mem_to_reg, pc_src, ext_op;
    logic [2:0] alu_op, state;

    // Expected outputs of one cycle, in the same field order as 'got'.
    typedef struct packed {
        logic [2:0] st;
        logic       pc_we;
        logic       ir_we;
        logic       reg_we;
        logic       mem_re;
        logic       mem_we;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] pc_src;
        logic       alu_src_b;
        logic [1:0] ext_op;
        logic [2:0] alu_op;
        logic       illegal;
    } exp_t;

    // One planned cycle: the inputs to drive and the outputs to expect.
    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       mr;
        exp_t       e;
    } cyc_t;

    typedef enum {K_BAD, K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW,
                  K_BEQ, K_J, K_JAL, K_JR} kind_t;

    exp_t got;
    exp_t rst_exp;
    exp_t expq[$];
    cyc_t plan[$];
    int   vectors;
    int   miscompares;
    int   cyc;

    assign got = {state, pc_we, ir_we, reg_we, mem_re, mem_we, reg_dst,
                  mem_to_reg, pc_src, alu_src_b, ext_op, alu_op, illegal};

    mc_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .reg_we     (reg_we),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .pc_src     (pc_src),
        .alu_src_b  (alu_src_b),
        .ext_op     (ext_op),
        .alu_op     (alu_op),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Map an instruction word to its class; unsupported encodings give K_BAD.
    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        kind_t k;
        k = K_BAD;
        case (op)
            6'h00:   k = (fn == 6'h21) ? K_ADDU : (fn == 6'h23) ? K_SUBU :
                         (fn == 6'h08 && JJ_EN) ? K_JR : K_BAD;
            6'h0D:   k = K_ORI;
            6'h0F:   k = K_LUI;
            6'h23:   k = K_LW;
            6'h2B:   k = K_SW;
            6'h04:   k = K_BEQ;
            6'h02:   k = K_J;
            6'h03:   k = JJ_EN ? K_JAL : K_BAD;
            default: k = K_BAD;
        endcase
        return k;
    endfunction

    // A fresh cycle with all outputs 0; zero and mem_ready are random noise.
    function automatic cyc_t blank(input logic [5:0] op, input logic [5:0] fn);
        cyc_t c;
        c.op = op;
        c.fn = fn;
        c.z  = 1'($urandom);
        c.mr = 1'($urandom);
        c.e  = '0;
        return c;
    endfunction

    // Build the expected cycle list for one instruction into 'plan'.
    task automatic build(input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input int waits);
        kind_t k;
        cyc_t  c;
        k = classify(op, fn);
        plan.delete();
        c = blank(op, fn); c.e.st = 3'd0; c.e.ir_we = 1'b1; c.e.pc_we = 1'b1;
        plan.push_back(c);
        c = blank(op, fn); c.e.st = 3'd1; c.e.illegal = (k == K_BAD);
        plan.push_back(c);
        if (k == K_BAD) return;
        c = blank(op, fn); c.e.st = 3'd2; c.z = z;
        case (k)
            K_SUBU: c.e.alu_op = 3'd1;
            K_ORI:  begin c.e.alu_op = 3'd2; c.e.alu_src_b = 1'b1; end
            K_LUI:  begin c.e.alu_src_b = 1'b1; c.e.ext_op = 2'd2; end
            K_LW, K_SW: begin c.e.alu_src_b = 1'b1; c.e.ext_op = 2'd1; end
            K_BEQ:  begin c.e.alu_op = 3'd1; c.e.pc_src = 2'd1; c.e.pc_we = z; end
            K_J:    begin c.e.pc_src = 2'd2; c.e.pc_we = 1'b1; end
            K_JAL:  begin c.e.pc_src = 2'd2; c.e.pc_we = 1'b1; c.e.reg_we = 1'b1;
                          c.e.reg_dst = 2'd2; c.e.mem_to_reg = 2'd2; end
            K_JR:   begin c.e.pc_src = 2'd3; c.e.pc_we = 1'b1; end
            default: ;
        endcase
        plan.push_back(c);
        if (k == K_BEQ || k == K_J || k == K_JAL || k == K_JR) return;
        if (k == K_LW || k == K_SW) begin
            for (int w = 0; w <= waits; w++) begin
                c = blank(op, fn); c.e.st = 3'd3;
                c.e.mem_re = (k == K_LW); c.e.mem_we = (k == K_SW);
                c.mr = (w == waits);
                plan.push_back(c);
            end
            if (k == K_SW) return;
        end
        c = blank(op, fn); c.e.st = 3'd4; c.e.reg_we = 1'b1;
        c.e.reg_dst = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
        c.e.mem_to_reg = (k == K_LW) ? 2'd1 : 2'd0;
        plan.push_back(c);
    endtask

    task automatic check_val(input string name, input int actual, input int required);
        vectors++;
        if (actual != required) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    task automatic check_out(input string name, input exp_t required);
        vectors++;
        if (got !== required) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", name, got, required);
        end
    endtask

    // Compare process: one planned cycle per falling edge.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            cyc++;
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL outputs cyc=%0d op=%h fn=%h got=%b expected=%b",
                         cyc, opcode, funct, got, e);
            end else begin
                $display("cyc=%0d op=%h fn=%h state=%0d ok", cyc, opcode, funct, state);
            end
        end
    end

    // Run one instruction. If abort_at >= 0, assert reset mid-cycle after that
    // planned cycle and check that every output falls to the reset value at once.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int waits, input int abort_at);
        build(op, fn, z, waits);
        foreach (plan[i]) begin
            @(posedge clk); #1;
            opcode    = plan[i].op;
            funct     = plan[i].fn;
            zero      = plan[i].z;
            mem_ready = plan[i].mr;
            expq.push_back(plan[i].e);
            if (i == abort_at) begin
                @(negedge clk); #1;
                rst_n = 1'b0;
                #1;
                check_out("async_reset_mid_instr", rst_exp);
                @(posedge clk); #1;
                rst_n = 1'b1;
                expq.push_back(rst_exp);
                return;
            end
        end
    endtask

    initial begin
        int mem_count;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rst_n       = 1'b0;
        opcode      = 6'h00;
        funct       = 6'h00;
        zero        = 1'b0;
        mem_ready   = 1'b0;
        rst_exp     = '0;
        rst_exp.st  = 3'd7;

        // Hand-computed cycle counts that pin the model itself.
        build(6'h00, 6'h21, 1'b0, 0); check_val("model_addu_len", plan.size(), 4);
        check_val("model_addu_wb_dst", int'(plan[3].e.reg_dst), 1);
        build(6'h23, 6'h00, 1'b0, 0); check_val("model_lw_len", plan.size(), 5);
        build(6'h23, 6'h00, 1'b0, 2); check_val("model_lw_wait2_len", plan.size(), 7);
        mem_count = 0;
        foreach (plan[i]) if (plan[i].e.mem_re) mem_count++;
        check_val("model_lw_wait2_mem_re", mem_count, 3);
        build(6'h2B, 6'h00, 1'b0, 0); check_val("model_sw_len", plan.size(), 4);
        build(6'h04, 6'h00, 1'b1, 0); check_val("model_beq_len", plan.size(), 3);
        build(6'h3F, 6'h00, 1'b0, 0); check_val("model_bad_len", plan.size(), 2);
        build(6'h03, 6'h00, 1'b0, 0); check_val("model_jal_len", plan.size(), JJ_EN ? 3 : 2);

        // Reset held low: state is RST and every output is 0.
        @(posedge clk); #1;
        check_out("reset_held", rst_exp);
        @(posedge clk); #1;
        rst_n = 1'b1;
        expq.push_back(rst_exp);

        // Directed instructions.
        run_instr(6'h00, 6'h21, 1'b0, 0, -1);   // addu
        run_instr(6'h23, 6'h00, 1'b0, 2, -1);   // lw, two wait cycles
        run_instr(6'h04, 6'h00, 1'b1, 0, -1);   // beq taken
        run_instr(6'h04, 6'h00, 1'b0, 0, -1);   // beq not taken
        run_instr(6'h03, 6'h00, 1'b0, 0, -1);   // jal
        run_instr(6'h3F, 6'h00, 1'b0, 0, -1);   // illegal in both builds
        run_instr(6'h00, 6'h08, 1'b0, 0, -1);   // jr
        run_instr(6'h2B, 6'h00, 1'b0, 1, -1);   // sw, one wait cycle
        run_instr(6'h0F, 6'h00, 1'b0, 0, -1);   // lui
        run_instr(6'h0D, 6'h00, 1'b0, 0, -1);   // ori
        run_instr(6'h02, 6'h00, 1'b0, 0, -1);   // j
        run_instr(6'h23, 6'h00, 1'b0, 2, 4);    // lw, reset while waiting in MEM

        // Randomized instruction stream.
        for (int n = 0; n < 400; n++) begin
            logic [5:0] op;
            logic [5:0] fn;
            int sel;
            sel = int'($urandom_range(0, 11));
            fn  = 6'($urandom);
            case (sel)
                0:  begin op = 6'h00; fn = 6'h21; end
                1:  begin op = 6'h00; fn = 6'h23; end
                2:  op = 6'h0D;
                3:  op = 6'h0F;
                4:  op = 6'h23;
                5:  op = 6'h2B;
                6:  op = 6'h04;
                7:  op = 6'h02;
                8:  op = 6'h03;
                9:  begin op = 6'h00; fn = 6'h08; end
                10: op = 6'($urandom);
                default: op = 6'h00;
            endcase
            run_instr(op, fn, 1'($urandom), int'($urandom_range(0, 3)),
                      ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 5)) : -1);
        end

        // Drain the outstanding expectations with a bounded wait.
        for (int k = 0; k < 10 && expq.size() > 0; k++) @(negedge clk);
        #1;
        check_val("drain_pending", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
